// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package handshake_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Index width that never collapses to zero bits for a single requester.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational round-robin picker: first set request at or after base, wrapping.
module handshake_rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   output logic [N-1:0] grant,
   output logic [W-1:0] index,
   output logic         any
);

   logic [N-1:0] rot;
   logic [N-1:0] first;
   logic [W:0]   off;
   logic [W:0]   sum;

   always_comb begin
      // Rotate so that bit 0 is the base requester, scan, then rotate back.
      rot   = N'({req, req} >> base);
      first = '0;
      off   = '0;
      any   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rot[i] && !any) begin
            any      = 1'b1;
            first[i] = 1'b1;
            off      = (W+1)'(i);
         end
      end
      grant = N'(({first, first} << base) >> N);
      sum   = {1'b0, base} + off;
      if (sum >= (W+1)'(N)) begin
         sum = sum - (W+1)'(N);
      end
      index = sum[W-1:0];
   end

endmodule

// File: rtl/handshake_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered valid/ready channel.
//
//   state | meaning
//   IDLE  | between packets; round-robin pick among all valid requesters
//   LOCK  | mid-packet; only owner_q may send until its last beat transfers
module handshake_rr_packet_arbiter
   import handshake_arb_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int DATA_W = 32,
   localparam int ID_W   = clog2_min1(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        m_valid,
   input  logic [N_REQ*DATA_W-1:0] m_data,
   input  logic [N_REQ-1:0]        m_last,
   output logic [N_REQ-1:0]        m_ready,
   output logic                    s_valid,
   output logic [DATA_W-1:0]       s_data,
   output logic                    s_last,
   output logic [ID_W-1:0]         s_id,
   input  logic                    s_ready
);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;
   logic              s_last_q, s_last_d;
   logic [ID_W-1:0]   s_id_q, s_id_d;

   logic [N_REQ-1:0]  pick_grant;
   logic [ID_W-1:0]   pick_idx;
   logic              pick_any;

   logic              load_en;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   win_idx;
   logic [DATA_W-1:0] beat_data;
   logic              beat_last;
   logic              xfer;

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
      return (p == ID_W'(N_REQ - 1)) ? '0 : p + ID_W'(1);
   endfunction

   handshake_rr_pick #(
      .N (N_REQ),
      .W (ID_W)
   ) u_pick (
      .req   (m_valid),
      .base  (rr_ptr_q),
      .grant (pick_grant),
      .index (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      load_en = ~s_valid_q | s_ready;
      if (state_q == LOCK) begin
         grant   = m_valid & (N_REQ'(1) << owner_q);
         win_idx = owner_q;
      end else begin
         grant   = pick_any ? pick_grant : '0;
         win_idx = pick_idx;
      end
      m_ready   = load_en ? grant : '0;
      beat_data = '0;
      beat_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            beat_data = m_data[i*DATA_W +: DATA_W];
            beat_last = m_last[i];
         end
      end
      // grant only ever selects valid requesters, so any ready bit is a transfer
      xfer = |m_ready;
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_last_d  = s_last_q;
      s_id_d    = s_id_q;

      if (load_en) begin
         s_valid_d = xfer;
         if (xfer) begin
            s_data_d = beat_data;
            s_last_d = beat_last;
            s_id_d   = win_idx;
         end
      end

      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (beat_last) begin
                  rr_ptr_d = next_ptr(win_idx);
               end else begin
                  state_d = LOCK;
                  owner_d = win_idx;
               end
            end
         end
         LOCK: begin
            if (xfer && beat_last) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr(owner_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_last_q  <= 1'b0;
         s_id_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_last_q  <= s_last_d;
         s_id_q    <= s_id_d;
      end
   end

   assign s_valid = s_valid_q;
   assign s_data  = s_data_q;
   assign s_last  = s_last_q;
   assign s_id    = s_id_q;

endmodule
